// File: rtl/req_encoder_rr.sv
// req_encoder_rr: sticky request collector granting one binary index per valid/ready handshake, fixed (RR=0) or round-robin (RR=1) priority; ports clk, rst_n, req_i, out_ready -> out_valid, out_idx, out_multi, pending_o, drop_o
module req_encoder_rr #(
  parameter int N = 8,
  parameter bit RR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_multi,
  output logic [N-1:0]         pending_o,
  output logic                 drop_o
);
  localparam int W = $clog2(N);
  localparam logic [N-1:0] lsb = {{(N-1){1'b0}}, 1'b1};
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [N-1:0] pending_q, pending_d, clr, cand;
  logic [W-1:0] idx_q, idx_d, ptr_q, ptr_d, start;
  logic valid_q, valid_d, multi_q, multi_d, drop_q, drop_d, hs;
  function automatic logic [W-1:0] pick(input logic [N-1:0] c, input logic [W-1:0] s);
    logic [W-1:0] r;
    logic f;
    logic [W:0] j;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, s} + (W+1)'(i);
      if (j >= (W+1)'(N)) j = j - (W+1)'(N);
      if (!f && c[j[W-1:0]]) begin
        r = j[W-1:0];
        f = 1'b1;
      end
    end
    return r;
  endfunction
  always_comb begin
    hs = valid_q && out_ready;
    clr = hs ? lsb << idx_q : '0;
    pending_d = (pending_q & ~clr) | req_i;
    drop_d = |(req_i & pending_q & ~clr);
    ptr_d = hs ? idx_q : ptr_q;
    start = RR ? ((ptr_d == W'(N-1)) ? '0 : ptr_d + W'(1)) : '0;
    cand = pending_q & ~clr;
    state_d = state_q;
    valid_d = valid_q;
    idx_d = idx_q;
    multi_d = multi_q;
    if (state_q == IDLE || hs) begin
      state_d = |cand ? HOLD : IDLE;
      valid_d = |cand;
      idx_d = |cand ? pick(cand, start) : idx_q;
      multi_d = |cand ? |(cand & (cand - lsb)) : multi_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pending_q <= '0;
      idx_q <= '0;
      ptr_q <= W'(N-1);
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      drop_q <= drop_d;
    end
  end
  assign out_valid = valid_q;
  assign out_idx = idx_q;
  assign out_multi = multi_q;
  assign pending_o = pending_q;
  assign drop_o = drop_q;
endmodule

// File: tb/tb_req_encoder_rr.sv
// tb_req_encoder_rr: scoreboard bench driving a fixed-priority and a round-robin instance against a behavioural model
module tb_req_encoder_rr;
  localparam int N = 8;
  typedef struct packed {
    logic [1:0]        v;
    logic [1:0][2:0]   idx;
    logic [1:0]        multi;
    logic [1:0][N-1:0] pend;
    logic [1:0]        drop;
  } snap_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic rdy = 1'b0;
  logic [1:0] ov, om, od;
  logic [1:0][2:0] oi;
  logic [1:0][N-1:0] op;
  logic [1:0][N-1:0] m_pend;
  logic [1:0] m_v, m_m, m_d;
  logic [1:0][2:0] m_i, m_p;
  snap_t exp_q[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  req_encoder_rr #(.N(N), .RR(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .req_i(req), .out_ready(rdy),
    .out_valid(ov[0]), .out_idx(oi[0]), .out_multi(om[0]), .pending_o(op[0]), .drop_o(od[0]));
  req_encoder_rr #(.N(N), .RR(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .req_i(req), .out_ready(rdy),
    .out_valid(ov[1]), .out_idx(oi[1]), .out_multi(om[1]), .pending_o(op[1]), .drop_o(od[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int sel(input logic [N-1:0] c, input int ptr, input int rr);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = rr != 0 ? (ptr + k) % N : k - 1;
      if (c[i]) return i;
    end
    return 0;
  endfunction
  function automatic snap_t model_snap();
    snap_t s;
    s.v = m_v;
    s.idx = m_i;
    s.multi = m_m;
    s.pend = m_pend;
    s.drop = m_d;
    return s;
  endfunction
  task automatic step(input logic [N-1:0] r, input logic rd);
    @(negedge clk);
    rst_n = 1'b1;
    req = r;
    rdy = rd;
    for (int u = 0; u < 2; u++) begin
      logic hs;
      logic [N-1:0] clr, cand;
      hs = m_v[u] && rd;
      clr = '0;
      if (hs) clr[m_i[u]] = 1'b1;
      cand = m_pend[u] & ~clr;
      m_d[u] = |(r & m_pend[u] & ~clr);
      if (hs) m_p[u] = m_i[u];
      if (!m_v[u] || hs) begin
        m_v[u] = cand != '0;
        if (cand != '0) begin
          m_i[u] = 3'(sel(cand, int'(m_p[u]), u));
          m_m[u] = $countones(cand) > 1;
        end
      end
      m_pend[u] = (m_pend[u] & ~clr) | r;
    end
    exp_q.push_back(model_snap());
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    rdy = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d rst valid", u), 32'(ov[u]), 0);
      chk($sformatf("u%0d rst idx", u), 32'(oi[u]), 0);
      chk($sformatf("u%0d rst multi", u), 32'(om[u]), 0);
      chk($sformatf("u%0d rst pend", u), 32'(op[u]), 0);
      chk($sformatf("u%0d rst drop", u), 32'(od[u]), 0);
      m_pend[u] = '0;
      m_v[u] = 1'b0;
      m_i[u] = '0;
      m_m[u] = 1'b0;
      m_d[u] = 1'b0;
      m_p[u] = 3'(N - 1);
    end
    exp_q.push_back(model_snap());
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        snap_t e;
        e = exp_q.pop_front();
        for (int u = 0; u < 2; u++) begin
          chk($sformatf("u%0d valid", u), 32'(ov[u]), 32'(e.v[u]));
          chk($sformatf("u%0d pending", u), 32'(op[u]), 32'(e.pend[u]));
          chk($sformatf("u%0d drop", u), 32'(od[u]), 32'(e.drop[u]));
          if (e.v[u]) begin
            chk($sformatf("u%0d idx", u), 32'(oi[u]), 32'(e.idx[u]));
            chk($sformatf("u%0d multi", u), 32'(om[u]), 32'(e.multi[u]));
          end
        end
      end
    end
  end
  initial begin
    do_reset();
    step(8'h20, 1'b1);
    repeat (3) step(8'h00, 1'b1);
    step(8'h81, 1'b1);
    repeat (4) step(8'h00, 1'b1);
    repeat (12) step(8'hFF, 1'b1);
    repeat (10) step(8'h00, 1'b1);
    step(8'h04, 1'b0);
    step(8'h00, 1'b0);
    step(8'h10, 1'b0);
    step(8'h10, 1'b0);
    step(8'h00, 1'b0);
    repeat (4) step(8'h00, 1'b1);
    step(8'h08, 1'b0);
    step(8'h00, 1'b0);
    step(8'h08, 1'b1);
    repeat (3) step(8'h00, 1'b1);
    step(8'h0F, 1'b0);
    step(8'h00, 1'b0);
    do_reset();
    step(8'h0C, 1'b1);
    repeat (4) step(8'h00, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      if ($urandom_range(0, 249) == 0) do_reset();
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      step(r, $urandom_range(0, 3) != 0);
    end
    repeat (3) @(negedge clk);
    chk("queue drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
